// File: rtl/user_fifos_pkg.sv
// Shared defaults and helpers for the user-side request FIFOs.
package user_fifos_pkg;

  localparam int UF_ADDR_WIDTH = 15;
  localparam int UF_DATA_WIDTH = 32;
  localparam int UF_OWNER_W    = 2;
  localparam int UF_DEPTH_LOG2 = 2;

  // RAF entry layout is {block, owner, addr}.
  function automatic int raf_width(input int addr_w);
    return 1 + UF_OWNER_W + addr_w;
  endfunction

endpackage

// File: rtl/ufifo_sync.sv
// Synchronous first-word-fall-through FIFO with an asynchronous active-low reset.
// dout_o always shows the entry at the head pointer.
module ufifo_sync #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_n_o,
  output logic             full_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [DEPTH_LOG2-1:0]       head_q, tail_q;
  logic [DEPTH_LOG2:0]         cnt_q, cnt_d;
  logic                        do_push, do_pop;

  assign full_o    = (cnt_q == CNT_FULL);
  assign empty_n_o = (cnt_q != '0);
  assign dout_o    = mem_q[head_q];

  // A push into a full FIFO and a pop from an empty one are both ignored.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & empty_n_o;

  // Occupancy next-state: push and pop together leave the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  // Storage, pointers and count; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      mem_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[tail_q] <= din_i;
        tail_q        <= tail_q + 1'b1;
      end
      if (do_pop) head_q <= head_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/user_fifos.sv
// User-side request buffering for the DDR command sequencer: a read-address
// FIFO plus write-address and write-data FIFOs pushed in lock-step.
module user_fifos
  import user_fifos_pkg::*;
#(
  parameter int ADDR_WIDTH  = UF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = UF_DATA_WIDTH,
  parameter int BYTES_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH_LOG2  = UF_DEPTH_LOG2
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  // read request side
  input  logic                   rd_req_i,
  input  logic                   rd_block_i,
  output logic                   rd_busy_o,
  input  logic [UF_OWNER_W-1:0]  rd_owner_i,
  input  logic [ADDR_WIDTH-1:0]  rd_addr_i,
  // write request side
  input  logic                   wr_req_i,
  output logic                   wr_busy_o,
  input  logic [ADDR_WIDTH-1:0]  wr_addr_i,
  input  logic [BYTES_WIDTH-1:0] wr_bytes_i,
  input  logic [DATA_WIDTH-1:0]  wr_data_i,
  // sequencer side
  input  logic                   raf_read_i,
  output logic                   raf_block_o,
  output logic                   raf_empty_no,
  output logic [UF_OWNER_W-1:0]  raf_owner_o,
  output logic [ADDR_WIDTH-1:0]  raf_addr_o,
  input  logic                   waf_read_i,
  output logic                   waf_empty_no,
  output logic [ADDR_WIDTH-1:0]  waf_addr_o,
  input  logic                   wdf_read_i,
  output logic [BYTES_WIDTH-1:0] wdf_bytes_o,
  output logic [DATA_WIDTH-1:0]  wdf_data_o
);

  localparam int RAF_W = raf_width(ADDR_WIDTH);
  localparam int WDF_W = BYTES_WIDTH + DATA_WIDTH;

  logic             waf_full, wdf_full, wr_push;
  logic             wdf_empty_n;
  logic [RAF_W-1:0] raf_dout;
  logic [WDF_W-1:0] wdf_dout;

  assign wr_busy_o = waf_full | wdf_full;
  // Both write FIFOs take the entry or neither does, keeping them aligned.
  assign wr_push   = wr_req_i & ~wr_busy_o;

  ufifo_sync #(.WIDTH(RAF_W), .DEPTH_LOG2(DEPTH_LOG2)) u_raf (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .push_i    (rd_req_i),
    .pop_i     (raf_read_i),
    .din_i     ({rd_block_i, rd_owner_i, rd_addr_i}),
    .dout_o    (raf_dout),
    .empty_n_o (raf_empty_no),
    .full_o    (rd_busy_o)
  );

  assign {raf_block_o, raf_owner_o, raf_addr_o} = raf_dout;

  ufifo_sync #(.WIDTH(ADDR_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_waf (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .push_i    (wr_push),
    .pop_i     (waf_read_i),
    .din_i     (wr_addr_i),
    .dout_o    (waf_addr_o),
    .empty_n_o (waf_empty_no),
    .full_o    (waf_full)
  );

  // WDF occupancy is not exported; the sequencer tracks it via the WAF.
  ufifo_sync #(.WIDTH(WDF_W), .DEPTH_LOG2(DEPTH_LOG2)) u_wdf (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .push_i    (wr_push),
    .pop_i     (wdf_read_i),
    .din_i     ({wr_bytes_i, wr_data_i}),
    .dout_o    (wdf_dout),
    .empty_n_o (wdf_empty_n),
    .full_o    (wdf_full)
  );

  assign {wdf_bytes_o, wdf_data_o} = wdf_dout;

endmodule

// File: tb/tb_user_fifos.sv
// Directed bench for user_fifos: reset, FWFT timing, full/empty boundaries,
// simultaneous push/pop and the lock-step write path.
module tb_user_fifos;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        rd_req_i, rd_block_i, rd_busy_o;
  logic [1:0]  rd_owner_i;
  logic [14:0] rd_addr_i;
  logic        wr_req_i, wr_busy_o;
  logic [14:0] wr_addr_i;
  logic [3:0]  wr_bytes_i;
  logic [31:0] wr_data_i;
  logic        raf_read_i, raf_block_o, raf_empty_no;
  logic [1:0]  raf_owner_o;
  logic [14:0] raf_addr_o;
  logic        waf_read_i, waf_empty_no;
  logic [14:0] waf_addr_o;
  logic        wdf_read_i;
  logic [3:0]  wdf_bytes_o;
  logic [31:0] wdf_data_o;

  int tests = 0;
  int failed = 0;

  user_fifos dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .rd_req_i(rd_req_i), .rd_block_i(rd_block_i), .rd_busy_o(rd_busy_o),
    .rd_owner_i(rd_owner_i), .rd_addr_i(rd_addr_i),
    .wr_req_i(wr_req_i), .wr_busy_o(wr_busy_o), .wr_addr_i(wr_addr_i),
    .wr_bytes_i(wr_bytes_i), .wr_data_i(wr_data_i),
    .raf_read_i(raf_read_i), .raf_block_o(raf_block_o), .raf_empty_no(raf_empty_no),
    .raf_owner_o(raf_owner_o), .raf_addr_o(raf_addr_o),
    .waf_read_i(waf_read_i), .waf_empty_no(waf_empty_no), .waf_addr_o(waf_addr_o),
    .wdf_read_i(wdf_read_i), .wdf_bytes_o(wdf_bytes_o), .wdf_data_o(wdf_data_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic push_rd(input logic [14:0] a);
    rd_req_i = 1'b1; rd_addr_i = a; tick(); rd_req_i = 1'b0;
  endtask

  task automatic pop_rd();
    raf_read_i = 1'b1; tick(); raf_read_i = 1'b0;
  endtask

  task automatic push_wr(input logic [14:0] a, input logic [3:0] b, input logic [31:0] d);
    wr_req_i = 1'b1; wr_addr_i = a; wr_bytes_i = b; wr_data_i = d; tick(); wr_req_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b0;
    rd_req_i = 0; rd_block_i = 0; rd_owner_i = 0; rd_addr_i = 0;
    wr_req_i = 0; wr_addr_i = 0; wr_bytes_i = 0; wr_data_i = 0;
    raf_read_i = 0; waf_read_i = 0; wdf_read_i = 0;
    #12;
    chk("rst_raf_empty_n", raf_empty_no, 0);
    chk("rst_waf_empty_n", waf_empty_no, 0);
    chk("rst_busy", {rd_busy_o, wr_busy_o}, 0);
    @(negedge clock_i); reset_i = 1'b1;
    tick();

    // X on read fields while rd_req is low must not create an entry
    rd_block_i = 1'bx; rd_owner_i = 2'bxx; tick();
    chk("x_idle_empty_n", raf_empty_no, 0);

    // single read, FWFT
    rd_req_i = 1; rd_owner_i = 2'b10; rd_block_i = 0; rd_addr_i = 15'd10;
    tick();
    rd_req_i = 0; rd_addr_i = 15'd57;
    chk("single_empty_n", raf_empty_no, 1);
    chk("single_owner", raf_owner_o, 2);
    chk("single_block", raf_block_o, 0);
    chk("single_addr", raf_addr_o, 10);
    tick();
    chk("single_addr_hold", raf_addr_o, 10);
    pop_rd();
    chk("single_pop_empty_n", raf_empty_no, 0);

    // fill RAF, 5th push dropped
    for (int i = 1; i <= 5; i++) begin
      rd_req_i = 1; rd_addr_i = 15'(i); tick();
      if (i == 3) chk("fill_busy_at3", rd_busy_o, 0);
      if (i == 4) chk("fill_busy_at4", rd_busy_o, 1);
    end
    rd_req_i = 0;
    chk("fill_busy_after5", rd_busy_o, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("fill_pop_addr", raf_addr_o, 15'(i));
      pop_rd();
    end
    chk("fill_drained_empty_n", raf_empty_no, 0);
    chk("fill_drained_busy", rd_busy_o, 0);

    // simultaneous push/pop at count 2
    push_rd(15'd20); push_rd(15'd21);
    rd_req_i = 1; rd_addr_i = 15'd22; raf_read_i = 1; tick();
    rd_req_i = 0; raf_read_i = 0;
    chk("pp2_head", raf_addr_o, 21);
    pop_rd();
    chk("pp2_head2", raf_addr_o, 22);
    pop_rd();
    chk("pp2_empty_n", raf_empty_no, 0);

    // simultaneous push/pop when full: pop only
    for (int i = 0; i < 4; i++) push_rd(15'(30 + i));
    chk("ppf_busy", rd_busy_o, 1);
    rd_req_i = 1; rd_addr_i = 15'd34; raf_read_i = 1; tick();
    rd_req_i = 0; raf_read_i = 0;
    chk("ppf_busy_after", rd_busy_o, 0);
    for (int i = 1; i <= 3; i++) begin
      chk("ppf_pop_addr", raf_addr_o, 15'(30 + i));
      pop_rd();
    end
    chk("ppf_empty_n", raf_empty_no, 0);

    // write path
    push_wr(15'h1A, 4'b0011, 32'hDEADBEEF);
    chk("wr_waf_empty_n", waf_empty_no, 1);
    chk("wr_waf_addr", waf_addr_o, 15'h1A);
    chk("wr_wdf_bytes", wdf_bytes_o, 4'h3);
    chk("wr_wdf_data", wdf_data_o, 32'hDEADBEEF);
    push_wr(15'h2B, 4'hF, 32'h12345678);
    waf_read_i = 1; tick(); waf_read_i = 0;
    chk("wr_waf_pop_addr", waf_addr_o, 15'h2B);
    chk("wr_wdf_untouched", wdf_data_o, 32'hDEADBEEF);
    waf_read_i = 1; tick(); waf_read_i = 0;
    chk("wr_waf_empty_after", waf_empty_no, 0);
    chk("wr_wdf_still", wdf_data_o, 32'hDEADBEEF);
    wdf_read_i = 1; tick(); wdf_read_i = 0;
    chk("wr_wdf_pop_data", wdf_data_o, 32'h12345678);
    chk("wr_wdf_pop_bytes", wdf_bytes_o, 4'hF);
    wdf_read_i = 1; tick(); wdf_read_i = 0;

    // wr_busy is the OR of both sides being full
    for (int i = 0; i < 4; i++) push_wr(15'(40 + i), 4'(i), 32'(100 + i));
    chk("wbusy_full", wr_busy_o, 1);
    waf_read_i = 1; tick(); waf_read_i = 0;
    chk("wbusy_wdf_full", wr_busy_o, 1);
    push_wr(15'h7F, 4'h9, 32'hBAD);
    chk("wbusy_drop_waf_head", waf_addr_o, 41);
    wdf_read_i = 1; tick(); wdf_read_i = 0;
    chk("wbusy_clear", wr_busy_o, 0);
    chk("wbusy_wdf_head", wdf_data_o, 101);

    // asynchronous reset mid-run with entries present
    push_rd(15'd77);
    @(posedge clock_i); #3;
    reset_i = 1'b0;
    #1;
    chk("mid_rst_raf_empty_n", raf_empty_no, 0);
    chk("mid_rst_waf_empty_n", waf_empty_no, 0);
    chk("mid_rst_busy", {rd_busy_o, wr_busy_o}, 0);
    chk("mid_rst_raf_out", {raf_block_o, raf_owner_o, raf_addr_o}, 0);
    chk("mid_rst_waf_addr", waf_addr_o, 0);
    chk("mid_rst_wdf_out", {wdf_bytes_o, wdf_data_o}, 0);
    @(negedge clock_i); reset_i = 1'b1;
    tick();

    // pop on empty is ignored; next push reads back correctly
    pop_rd();
    chk("pop_empty_empty_n", raf_empty_no, 0);
    rd_owner_i = 2'b01; rd_block_i = 1'b1;
    push_rd(15'd99);
    chk("after_pe_empty_n", raf_empty_no, 1);
    chk("after_pe_out", {raf_block_o, raf_owner_o, raf_addr_o}, {1'b1, 2'b01, 15'd99});
    pop_rd();
    chk("after_pe_drained", raf_empty_no, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
